// File: rtl/uart_rx_frontend_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend_if
// Bundles the serial line and the byte-strobe outputs of the UART receiver.
//   rx        : raw serial line, idle high (driven by the line side)
//   rx_data   : last correctly framed byte
//   rx_valid  : one-cycle strobe, rx_data holds a new byte
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : receiver is inside a frame or waiting out a break
// master : the receiver itself; slave : the line driver / byte consumer.
// ---------------------------------------------------------------------------
interface uart_rx_frontend_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
// 8N1 LSB-first serial receiver with 16x oversampling and 3-sample majority
// voting (samples 7, 8, 9 of each bit). Emits a byte strobe per good frame,
// a framing-error strobe on a low stop bit, and then ignores the line until
// it returns high so a break never produces spurious bytes.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : uart_rx_frontend_if.master (rx in; rx_data/rx_valid/frame_err/busy out)
// Parameters:
//   CLK_FREQ, BAUD : clock and bit rate; clocks per oversample tick is
//                    CLK_FREQ/(BAUD*16) and must be at least 1.
// ---------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frontend_if.master    bus
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [TW-1:0]   r_tick_cnt;
  logic [3:0]      r_samp_cnt;
  logic [2:0]      r_bit_idx;
  logic [1:0]      r_samp;      // [0] = sample 7, [1] = sample 8
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_frame_err;

  logic            w_active;
  logic            w_tick;
  logic            w_decide;
  logic            w_bit_end;
  logic            w_major;
  logic            w_shift_en;
  logic            w_load;
  logic            w_ferr;

  // Two-flop synchroniser; resets to the idle line level so reset release
  // never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Ticks only run inside a frame; IDLE/BREAK hold the counters at zero so
  // the sample phase is referenced to the detected start edge.
  assign w_active  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_tick    = w_active && (r_tick_cnt == TICK_LAST);
  assign w_decide  = w_tick && (r_samp_cnt == 4'd9);
  assign w_bit_end = w_tick && (r_samp_cnt == 4'd15);

  // Sample 9 is the live synchronised value on the deciding tick.
  assign w_major = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_decide && w_major) w_state_nxt = S_IDLE;   // false start
        else if (w_bit_end)      w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_shift_en = w_decide;
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leave at the stop-bit centre to tolerate fast back-to-back senders.
        if (w_decide) begin
          if (w_major) begin
            w_load      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_bit_idx  <= '0;
      r_samp     <= '0;
    end else if (!w_active) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= r_samp_cnt + 4'd1;                  // wraps 15 -> 0
      if (r_samp_cnt == 4'd7) r_samp[0] <= r_rx_s;
      if (r_samp_cnt == 4'd8) r_samp[1] <= r_rx_s;
      if (w_bit_end && (r_state == S_DATA)) r_bit_idx <= r_bit_idx + 3'd1;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // NOTE: the shift register and output byte are plain registers, not a
  // memory, so they take the reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_shift_en) r_shift <= {w_major, r_shift[7:1]};   // LSB arrives first
      if (w_load)     r_rx_data <= r_shift;
      r_rx_valid  <= w_load;
      r_frame_err <= w_ferr;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frontend
// Drives whole 8N1 frames cycle by cycle at DIV = 1 (16 clk per bit) and
// compares received bytes and strobes against a byte-level model: a frame
// decodes to its data byte, except that a data bit whose samples 7/8/9 have
// two or more inverted cycles decodes inverted.
// ---------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int BIT_CLK  = 16;          // DIV = 1
  localparam int FRAME    = 10 * BIT_CLK;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frontend_if intf ();

  uart_rx_frontend #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         valid_cyc  = 0;
  int         n_ferr     = 0;
  logic [7:0] ferr_data  = 8'h00;
  int         both_cnt   = 0;
  int         wide_cnt   = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;

  always @(negedge clk) begin
    if (intf.rx_valid) begin
      got_q.push_back(intf.rx_data);
      valid_cyc = cyc;
    end
    if (intf.frame_err) begin
      n_ferr++;
      ferr_data = intf.rx_data;
    end
    if (intf.rx_valid && intf.frame_err) both_cnt++;
    if ((intf.rx_valid && prev_valid) || (intf.frame_err && prev_ferr)) wide_cnt++;
    prev_valid = intf.rx_valid;
    prev_ferr  = intf.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One line cycle: rx changes 1 ns after the rising edge.
  task automatic put(input logic v);
    @(posedge clk);
    #1 intf.rx = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b1);
  endtask

  // Sends the first ncyc cycles of a frame. gbit selects a data bit (or -1)
  // whose samples 7/8/9 are inverted per gmask[0..2]. Sample k of bit slot b
  // sees the line value driven in cycle 16*b + k + 1 of the frame (two
  // synchroniser flops plus the start-detect cycle).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit,
                            input logic [2:0] gmask, input int ncyc, output int start_cyc);
    logic [FRAME-1:0] wave;
    logic             v;
    for (int b = 0; b < 10; b++) begin
      v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      for (int o = 0; o < BIT_CLK; o++) wave[b*BIT_CLK + o] = v;
    end
    if (gbit >= 0)
      for (int k = 0; k < 3; k++)
        if (gmask[k]) wave[(gbit+1)*BIT_CLK + 7 + k + 1] = ~wave[(gbit+1)*BIT_CLK + 7 + k + 1];
    start_cyc = 0;
    for (int i = 0; i < ncyc; i++) begin
      put(wave[i]);
      if (i == 0) start_cyc = cyc;
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] d, input int gbit,
                                            input logic [2:0] gmask);
    logic [7:0] r;
    r = d;
    if (gbit >= 0 && $countones(gmask) >= 2) r[gbit] = ~r[gbit];
    return r;
  endfunction

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] str[5];
    logic [7:0] b;
    logic [7:0] prior;
    logic [2:0] m;
    int         s0, g0, last_hi, seen_hi, gb, base_ferr;

    intf.rx = 1'b1;

    // ---- reset state ----
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data",   intf.rx_data,   8'h00);
    check("rst_rx_valid",  intf.rx_valid,  1'b0);
    check("rst_frame_err", intf.frame_err, 1'b0);
    check("rst_busy",      intf.busy,      1'b0);
    rst = 1'b0;
    idle(5);

    // ---- basic byte and latency ----
    got_q.delete();
    send_frame(8'h48, 1'b1, -1, 3'b000, FRAME, s0);
    idle(20);
    check("basic_count", got_q.size(), 1);
    if (got_q.size() > 0) check("basic_data", got_q[0], 8'h48);
    check("basic_lat_157pm1", (valid_cyc - s0 >= 156) && (valid_cyc - s0 <= 158), 1'b1);
    check("basic_no_ferr", n_ferr, 0);
    check("basic_busy_after", intf.busy, 1'b0);

    // ---- back-to-back string, no gaps ----
    got_q.delete();
    str = '{8'h44, 8'h43, 8'h35, 8'h30, 8'h0D};
    for (int i = 0; i < 5; i++) send_frame(str[i], 1'b1, -1, 3'b000, FRAME, s0);
    idle(20);
    check("str_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check($sformatf("str_byte%0d", i), got_q[i], str[i]);
    check("str_no_ferr", n_ferr, 0);

    // ---- glitch rejection ----
    got_q.delete();
    seen_hi = 0;
    last_hi = 0;
    g0 = 0;
    for (int i = 0; i < 30; i++) begin
      put(i < 4 ? 1'b0 : 1'b1);
      if (i == 0) g0 = cyc;
      if (intf.busy) begin
        seen_hi = 1;
        last_hi = cyc;
      end
    end
    check("glitch_busy_pulse", seen_hi, 1);
    check("glitch_busy_within12", (last_hi - g0) <= 12, 1'b1);
    check("glitch_busy_end", intf.busy, 1'b0);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_no_ferr", n_ferr, 0);

    // ---- majority vote, directed ----
    got_q.delete();
    send_frame(8'hA5, 1'b1, 2, 3'b010, FRAME, s0);
    send_frame(8'hA5, 1'b1, 2, 3'b011, FRAME, s0);
    idle(20);
    check("maj_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("maj_s8_only", got_q[0], model_byte(8'hA5, 2, 3'b010));
      check("maj_s7_s8",   got_q[1], model_byte(8'hA5, 2, 3'b011));
    end

    // ---- randomized frames with random sample inversions ----
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom_range(0, 255));
      gb = int'($urandom_range(0, 8)) - 1;
      m  = 3'($urandom_range(0, 7));
      exp_q.push_back(model_byte(b, gb, m));
      send_frame(b, 1'b1, gb, m, FRAME, s0);
    end
    idle(20);
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
    check("rand_no_ferr", n_ferr, 0);

    // ---- framing error followed by a held-low break ----
    prior = intf.rx_data;
    base_ferr = n_ferr;
    got_q.delete();
    send_frame(8'h55, 1'b0, -1, 3'b000, FRAME, s0);
    for (int i = 0; i < 400; i++) put(1'b0);
    idle(5);
    check("brk_one_ferr", n_ferr - base_ferr, 1);
    check("brk_data_kept", ferr_data, prior);
    check("brk_no_valid", got_q.size(), 0);
    send_frame(8'h0D, 1'b1, -1, 3'b000, FRAME, s0);
    idle(20);
    check("brk_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("brk_next_data", got_q[0], 8'h0D);

    // ---- reset in the middle of data bit 3 ----
    got_q.delete();
    base_ferr = n_ferr;
    send_frame(8'h31, 1'b1, -1, 3'b000, 4 * BIT_CLK + 7, s0);
    check("pre_rst_busy", intf.busy, 1'b1);
    rst = 1'b1;
    intf.rx = 1'b1;
    #1;
    check("arst_rx_data",   intf.rx_data,   8'h00);
    check("arst_rx_valid",  intf.rx_valid,  1'b0);
    check("arst_frame_err", intf.frame_err, 1'b0);
    check("arst_busy",      intf.busy,      1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(30);
    check("arst_no_strobe", got_q.size(), 0);
    send_frame(8'h32, 1'b1, -1, 3'b000, FRAME, s0);
    idle(20);
    check("arst_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("arst_next_data", got_q[0], 8'h32);
    check("arst_no_ferr", n_ferr - base_ferr, 0);

    // ---- strobe shape over the whole run ----
    check("strobe_exclusive", both_cnt, 0);
    check("strobe_one_cycle", wide_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Asynchronous serial receiver (8N1, LSB first) that converts the raw RX pin into byte strobes.
- Sits directly upstream of the command parser and drives its rx_data / rx_valid inputs.
- Uses 16x oversampling with 3-sample majority voting and reports framing errors.
- Holds off after a line break so the parser never sees spurious bytes.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIV, CLK_FREQ/(BAUD*16) (truncating integer division), clocks per oversample tick. Must be >= 1; values below 1 are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle strobe: rx_data holds a new byte.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=1): two-flop synchroniser = 1; state = IDLE; all counters = 0; shift register = 0; rx_data = 0x00; rx_valid = 0; frame_err = 0; busy = 0.
- Reset mid-frame aborts the frame with no strobe. The next frame after release is received normally.
- Synchroniser: rx passes through two flops (rx_s). All decisions use rx_s only, so input latency is 2 clk.
- Tick generator: tick_cnt counts 0..DIV-1 and a tick fires when it reaches DIV-1. It is held at 0 in IDLE and BREAK, so the phase aligns to the start edge.
- samp_cnt: 0..15, advances on each tick and wraps 15->0 at each bit boundary.
- Majority: the samples at samp_cnt 7, 8 and 9 are latched. The bit value is the majority of the three, decided on the tick where samp_cnt = 9.
- IDLE: on rx_s = 0, clear tick_cnt and samp_cnt and go to START.
- START: at the samp_cnt = 9 decision:
  - majority = 1: false start. Go to IDLE with no strobe.
  - otherwise: on the samp_cnt = 15 tick, go to DATA with bit_idx = 0.
- DATA:
  - At each samp_cnt = 9 decision, shift the majority bit into the MSB of the shift register (shift right), so that bit 0 arrives first.
  - On the samp_cnt = 15 tick, increment bit_idx.
  - After bit_idx 7 wraps, go to STOP.
- STOP: at the samp_cnt = 9 decision:
  - majority = 1: rx_data <= shift register; rx_valid = 1 on the next clk, for exactly one cycle; go to IDLE.
  - majority = 0: frame_err = 1 for exactly one cycle; rx_data is unchanged; go to BREAK.
  - Leaving at sample 9, not at the end of the stop bit, gives 0.4-bit slack for back-to-back frames and fast senders.
- BREAK: wait for rx_s = 1 on a clock, then go to IDLE. A held-low line produces exactly one frame_err and no further activity.
- rx_valid and frame_err are never asserted in the same cycle.
- busy is driven from the registered state.
- The block has no backpressure. rx_data is stable from rx_valid until the next rx_valid.
- Total latency: from the rx start falling edge to rx_valid is 2 (sync) + 1 (IDLE detect) + 9*16*DIV + 9*DIV + 1 clk, ±1 clk. With DIV = 1 this is 157 ±1.

Test Plan:
- Basic byte: CLK_FREQ=1600000, BAUD=100000 (DIV=1). Send 0x48 with a clean frame -> rx_valid one cycle high at 157±1 clk after the start edge, rx_data=0x48, frame_err never high, busy low afterwards.
- Back-to-back string: "DC50\r" (0x44 0x43 0x35 0x30 0x0D), 1 stop bit each, no gaps -> five rx_valid pulses with exactly those bytes in order, no frame_err.
- Glitch rejection: rx low for 4 clk then high -> no rx_valid or frame_err; busy pulses high then returns to 0 within 12 clk of the glitch start.
- Majority vote: 0xA5 with data bit 2 inverted only at sample 8 -> rx_data=0xA5. The same bit inverted at samples 7 and 8 -> rx_data=0xA1.
- Framing/break: 0x55 with stop bit low, line held low 400 clk, then released and 0x0D sent -> exactly one frame_err pulse, rx_data stays at its prior value, then rx_valid with 0x0D.
- Reset mid-frame: assert rst for 3 clk during data bit 3 of 0x31 -> all outputs 0 immediately (async), no strobe; the next 0x32 frame is received correctly.
